// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the MAC-side FIFO.
// Imported by the RAM primitive and the FIFO top.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_AFULL_LEVEL  = 28;
  localparam int DEF_AEMPTY_LEVEL = 4;

  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdpram_sync.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read port only updates when re is high; contents are never reset.
module sdpram_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on sdpram_sync with thresholds, error pulses
// and an optional first-word-fall-through output register.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_LEVEL  = DEF_AFULL_LEVEL,
  parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL,
  parameter bit FWFT         = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(1 << AW);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LEVEL);
  localparam logic [AW:0] ZERO     = '0;
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [AW:0]           wptr, rptr;
  logic [AW:0]           wptr_nxt, rptr_nxt, count_nxt;
  logic                  wr_acc, rd_acc;
  logic                  ram_we, ram_re;
  logic [AW-1:0]         ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;

  assign wr_acc    = wr_en && !full && !clear;
  assign rd_acc    = rd_en && !empty && !clear;
  assign count_nxt = count + {{AW{1'b0}}, wr_acc}
                           - {{AW{1'b0}}, rd_acc};
  assign wptr_nxt  = wptr + {{AW{1'b0}}, ram_we};
  assign ram_waddr = wptr[AW-1:0];

  sdpram_sync #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .Clk  (Clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(wr_data),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_q)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      count     <= count_nxt;
      full      <= count_nxt == DEPTH_C;
      empty     <= count_nxt == ZERO;
      afull     <= count_nxt >= AFULL_C;
      aempty    <= count_nxt <= AEMPTY_C;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  if (!FWFT) begin : g_std
    logic rd_pend;

    assign ram_we    = wr_acc;
    assign ram_re    = rd_acc;
    assign ram_raddr = rptr[AW-1:0];
    assign rptr_nxt  = rptr + {{AW{1'b0}}, rd_acc};

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        rd_pend  <= 1'b0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (clear) begin
        rd_pend  <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        rd_pend  <= rd_acc;
        rd_valid <= rd_pend;
        if (rd_pend) rd_data <= ram_q;
      end
    end
  end else begin : g_fwft
    // RAM holds only the words behind the head; ram_q always
    // prefetches the oldest of them so a pop never bubbles.
    logic [AW:0]           ram_cnt;
    logic                  to_head, pop_ram, coll, byp_vld;
    logic [DATA_WIDTH-1:0] byp_data;

    assign ram_cnt   = wptr - rptr;
    assign to_head   = wr_acc && (count == ZERO ||
                                  (rd_acc && count == ONE));
    assign pop_ram   = rd_acc && ram_cnt != ZERO;
    assign ram_we    = wr_acc && !to_head;
    assign rptr_nxt  = rptr + {{AW{1'b0}}, pop_ram};
    assign ram_raddr = rptr_nxt[AW-1:0];
    assign coll      = ram_we && ram_waddr == ram_raddr;
    assign ram_re    = !coll;

    // A word landing in the slot being prefetched is caught here
    // instead of being read back stale from the RAM.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        byp_vld  <= 1'b0;
        byp_data <= '0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (clear) begin
        byp_vld  <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        byp_vld  <= coll;
        if (coll) byp_data <= wr_data;
        rd_valid <= count_nxt != ZERO;
        if (to_head) rd_data <= wr_data;
        else if (pop_ram) rd_data <= byp_vld ? byp_data : ram_q;
      end
    end
  end

  ap_no_rdw: assert property (@(posedge Clk) disable iff (Reset)
    !(ram_we && ram_re && ram_waddr == ram_raddr));

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Bench for sync_fifo_ram: FWFT=0 and FWFT=1 instances share stimulus
// and are checked against a queue model and a vector table.
module tb_sync_fifo_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] d0, d1;
  logic       rv0, rv1;
  logic       full0, empty0, af0, ae0, ov0, un0;
  logic       full1, empty1, af1, ae1, ov1, un1;
  logic [2:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_fifo_ram #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_LEVEL(3),
    .AEMPTY_LEVEL(1), .FWFT(1'b0)
  ) u0 (
    .Clk(clk), .Reset(rst), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d0), .rd_valid(rv0), .full(full0),
    .empty(empty0), .afull(af0), .aempty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_ram #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_LEVEL(3),
    .AEMPTY_LEVEL(1), .FWFT(1'b1)
  ) u1 (
    .Clk(clk), .Reset(rst), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d1), .rd_valid(rv1), .full(full1),
    .empty(empty1), .afull(af1), .aempty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  // Reference model: contents as a queue, plus the output views.
  logic [7:0] q[$];
  logic       m_ov, m_un, m_pend, m_rv0;
  logic [7:0] m_pw, m_d0, m_d1;

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_un = 1'b0;
    m_pend = 1'b0; m_rv0 = 1'b0;
    m_pw = 8'h00; m_d0 = 8'h00; m_d1 = 8'h00;
  endtask

  task automatic model_edge();
    bit wa, ra;
    if (clear) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0;
      m_pend = 1'b0; m_rv0 = 1'b0;
    end else begin
      m_ov = wr_en && q.size() == 4;
      m_un = rd_en && q.size() == 0;
      wa = wr_en && q.size() < 4;
      ra = rd_en && q.size() > 0;
      m_rv0 = m_pend;
      if (m_pend) m_d0 = m_pw;
      if (ra) m_pw = q.pop_front();
      m_pend = ra;
      if (wa) q.push_back(wr_data);
    end
    if (q.size() > 0) m_d1 = q[0];
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    int sz;
    logic [5:0] ef;
    sz = q.size();
    ef = {sz == 4, sz == 0, sz >= 3, sz <= 1, m_ov, m_un};
    chk({tag, ".cnt0"}, {5'b0, cnt0}, 8'(sz));
    chk({tag, ".cnt1"}, {5'b0, cnt1}, 8'(sz));
    chk({tag, ".flg0"}, {2'b0, full0, empty0, af0, ae0, ov0, un0},
        {2'b0, ef});
    chk({tag, ".flg1"}, {2'b0, full1, empty1, af1, ae1, ov1, un1},
        {2'b0, ef});
    chk({tag, ".rv0"}, {7'b0, rv0}, {7'b0, m_rv0});
    chk({tag, ".d0"}, d0, m_d0);
    chk({tag, ".rv1"}, {7'b0, rv1}, {7'b0, sz != 0});
    chk({tag, ".d1"}, d1, m_d1);
  endtask

  task automatic step(bit w, bit r, bit c, logic [7:0] d, string tag);
    wr_en = w; rd_en = r; clear = c; wr_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit       wr, rd, clr;
    bit [7:0] din;
    bit [2:0] cnt;
    bit [5:0] flg;   // full empty afull aempty overflow underflow
    bit [1:0] rv;    // rd_valid of FWFT=0, FWFT=1
    bit [7:0] d0, d1;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 6'b000100, 2'b01, 8'h00, 8'h11};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 6'b000000, 2'b01, 8'h00, 8'h11};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3'd3, 6'b001000, 2'b01, 8'h00, 8'h11};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h44, 3'd4, 6'b101000, 2'b01, 8'h00, 8'h11};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h55, 3'd4, 6'b101010, 2'b01, 8'h00, 8'h11};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 6'b001000, 2'b01, 8'h00, 8'h22};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 6'b000000, 2'b11, 8'h11, 8'h33};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 6'b000100, 2'b11, 8'h22, 8'h44};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010100, 2'b10, 8'h33, 8'h44};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010101, 2'b10, 8'h44, 8'h44};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 6'b010100, 2'b00, 8'h44, 8'h44};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'hA5, 3'd1, 6'b000100, 2'b01, 8'h44, 8'hA5};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010100, 2'b00, 8'h44, 8'hA5};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 6'b010100, 2'b10, 8'hA5, 8'hA5};

    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all("reset");

    for (int i = 0; i < 14; i++) begin
      wr_en = tbl[i].wr; rd_en = tbl[i].rd;
      clear = tbl[i].clr; wr_data = tbl[i].din;
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d.cnt0", i), {5'b0, cnt0}, {5'b0, tbl[i].cnt});
      chk($sformatf("tbl%0d.cnt1", i), {5'b0, cnt1}, {5'b0, tbl[i].cnt});
      chk($sformatf("tbl%0d.flg0", i),
          {2'b0, full0, empty0, af0, ae0, ov0, un0}, {2'b0, tbl[i].flg});
      chk($sformatf("tbl%0d.flg1", i),
          {2'b0, full1, empty1, af1, ae1, ov1, un1}, {2'b0, tbl[i].flg});
      chk($sformatf("tbl%0d.rv", i), {6'b0, rv0, rv1}, {6'b0, tbl[i].rv});
      chk($sformatf("tbl%0d.d0", i), d0, tbl[i].d0);
      chk($sformatf("tbl%0d.d1", i), d1, tbl[i].d1);
    end

    // Wrap: hold count at 2 with simultaneous read and write.
    step(1'b1, 1'b0, 1'b0, 8'd0, "wrap_pre0");
    step(1'b1, 1'b0, 1'b0, 8'd1, "wrap_pre1");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i + 2), $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d.d1_order", i), d1, 8'(i + 1));
    end
    chk("wrap.count", {5'b0, cnt0}, 8'd2);

    // clear with a concurrent write at count 3.
    step(1'b1, 1'b0, 1'b0, 8'h77, "clr_pre");
    step(1'b1, 1'b0, 1'b1, 8'h88, "clr");
    chk("clr.empty", {7'b0, empty1}, 8'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, "clr_rd");

    // Randomised traffic, alternating fill- and drain-biased phases.
    for (int i = 0; i < 600; i++) begin
      bit w, r, c;
      if ((i / 40) % 2 == 0) begin
        w = $urandom_range(0, 3) != 0;
        r = $urandom_range(0, 3) == 0;
      end else begin
        w = $urandom_range(0, 3) == 0;
        r = $urandom_range(0, 3) != 0;
      end
      c = $urandom_range(0, 49) == 0;
      step(w, r, c, 8'($urandom), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a write burst.
    step(1'b0, 1'b0, 1'b1, 8'h00, "rst_pre");
    step(1'b1, 1'b0, 1'b0, 8'hC1, "burst0");
    step(1'b1, 1'b1, 1'b0, 8'hC2, "burst1");
    step(1'b1, 1'b0, 1'b0, 8'hC3, "burst2");
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_held");
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h5A, "post_wr");
    chk("post_wr.d1", d1, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 8'h00, "post_rd");
    step(1'b0, 1'b0, 1'b0, 8'h00, "post_idle");
    chk("post_idle.d0", d0, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
